regfile_sb: RTL and testbench

Parametrised successor to the 32x32 core register file. Two asynchronous read ports and one synchronous write port, plus:
- same-cycle write-to-read bypass;
- optional hardwired zero register;
- a hardware clear engine that zeroes every entry after reset or on request;
- a per-entry pending-write scoreboard for the pipeline hazard unit.
Sits between decode (reads, issue) and writeback (write) in the CPU datapath.

---
 rtl/regfile_sb.sv | 92 +++++++++
 tb/tb_regfile_sb.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one write port, write-to-read
// bypass, optional zero register, a sequential clear engine and a pending-write scoreboard.
module regfile_sb #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic [AWIDTH-1:0] wa,
  input  logic [DWIDTH-1:0] wd,
  input  logic [AWIDTH-1:0] ra1,
  input  logic [AWIDTH-1:0] ra2,
  output logic [DWIDTH-1:0] rd1,
  output logic [DWIDTH-1:0] rd2,
  input  logic              iss_en,
  input  logic [AWIDTH-1:0] iss_addr,
  output logic              rd1_pend,
  output logic              rd2_pend,
  output logic              busy
);
  localparam int DEPTH = 2**AWIDTH;

  typedef enum logic {CLEAR, READY} state_e;

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] idx_q, idx_d;
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic              wr_en;
  logic              hit1, hit2;

  assign busy = (state_q == CLEAR);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    wr_en   = 1'b0;
    case (state_q)
      CLEAR: begin
        idx_d = idx_q + 1'b1;
        if (clr)              idx_d   = '0;
        else if (idx_q == '1) state_d = READY;
      end
      READY: begin
        if (clr) begin
          state_d = CLEAR;
          idx_d   = '0;
          pend_d  = '0;
        end else begin
          wr_en = we && !(ZERO_REG && wa == '0);
          // Set after clear so a same-cycle re-issue keeps the entry pending.
          if (we) pend_d[wa] = 1'b0;
          if (iss_en && !(ZERO_REG && iss_addr == '0)) pend_d[iss_addr] = 1'b1;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      idx_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
    end
  end

  // The array has no reset; the clear engine zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) mem_q[idx_q] <= '0;
    else if (wr_en)       mem_q[wa]    <= wd;
  end

  assign hit1 = BYPASS && we && (wa == ra1);
  assign hit2 = BYPASS && we && (wa == ra2);

  assign rd1 = (busy || (ZERO_REG && ra1 == '0)) ? '0 : (hit1 ? wd : mem_q[ra1]);
  assign rd2 = (busy || (ZERO_REG && ra2 == '0)) ? '0 : (hit2 ? wd : mem_q[ra2]);

  assign rd1_pend = !busy && !hit1 && pend_q[ra1];
  assign rd2_pend = !busy && !hit2 && pend_q[ra2];

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed vector table, clear/reset sequences,
// a 64x8 instance, and random traffic against an array-based reference model.
module tb_regfile_sb;
  localparam int DW = 32, AW = 5, DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, clr, we, iss_en;
  logic [AW-1:0] wa, ra1, ra2, iss_addr;
  logic [DW-1:0] wd, rd1, rd2;
  logic          rd1_pend, rd2_pend, busy;

  logic          rst64 = 1'b1, clr64, we64, iss64;
  logic [2:0]    wa64, ra1_64, ra2_64, ia64;
  logic [63:0]   wd64, rd1_64, rd2_64;
  logic          p1_64, p2_64, busy64;

  regfile_sb u_dut (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .rd1_pend(rd1_pend), .rd2_pend(rd2_pend), .busy(busy)
  );

  regfile_sb #(.DWIDTH(64), .AWIDTH(3)) u_dut64 (
    .clk(clk), .rst(rst64), .clr(clr64), .we(we64), .wa(wa64), .wd(wd64),
    .ra1(ra1_64), .ra2(ra2_64), .rd1(rd1_64), .rd2(rd2_64),
    .iss_en(iss64), .iss_addr(ia64),
    .rd1_pend(p1_64), .rd2_pend(p2_64), .busy(busy64)
  );

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Reference model: clearing is modelled as "everything zero, unusable for DEPTH edges".
  logic [DW-1:0]    m_mem [DEPTH];
  logic [DEPTH-1:0] m_pend;
  int               m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  <= DEPTH;
      m_pend <= '0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
    end else if (m_cnt > 0) begin
      m_cnt <= clr ? DEPTH : m_cnt - 1;
    end else if (clr) begin
      m_cnt  <= DEPTH;
      m_pend <= '0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
    end else begin
      if (we && wa != 0) m_mem[wa] <= wd;
      if (we) m_pend[wa] <= 1'b0;
      if (iss_en && iss_addr != 0) m_pend[iss_addr] <= 1'b1;
    end
  end

  function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a);
    if (m_cnt > 0 || a == 0) return '0;
    if (we && wa == a) return wd;
    return m_mem[a];
  endfunction

  function automatic logic m_pd(input logic [AW-1:0] a);
    if (m_cnt > 0 || (we && wa == a)) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    clr = 0; we = 0; wa = '0; wd = '0; iss_en = 0; iss_addr = '0;
  endtask

  // Counts edges until busy drops; also checks blanking and injects a write on clear cycle 5.
  task automatic wait_ready(input bit s64, output int n, output int errs);
    n = 0; errs = 0;
    while (n < 200) begin
      if (!s64) begin we = (n == 4); wa = 5'd3; wd = 32'hAA; ra1 = 5'd3; end
      #4;
      if (!(s64 ? busy64 : busy)) break;
      if (s64) begin
        if (rd1_64 != 0 || rd2_64 != 0 || p1_64 || p2_64) errs++;
      end else begin
        if (rd1 != 0 || rd2 != 0 || rd1_pend || rd2_pend) errs++;
      end
      @(posedge clk); #1;
      n++;
    end
    if (!s64) we = 0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic we; logic [4:0] wa; logic [31:0] wd; logic [4:0] ra1, ra2;
    logic iss; logic [4:0] ia; logic [31:0] e1, e2; logic ep1, ep2;
  } vec_t;

  vec_t tv[14];
  int n, errs;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    tv[0]  = '{1'b1, 5'd7, 32'hDEADBEEF, 5'd7, 5'd0, 1'b0, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0};
    tv[1]  = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 1'b0, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
    tv[2]  = '{1'b1, 5'd0, 32'h1234,     5'd0, 5'd7, 1'b0, 5'd0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0};
    tv[3]  = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b1, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0};
    tv[4]  = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b1, 5'd9, 32'h0, 32'h0, 1'b0, 1'b0};
    tv[5]  = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd9, 1'b0, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1};
    tv[6]  = '{1'b1, 5'd9, 32'h99,       5'd0, 5'd9, 1'b0, 5'd0, 32'h0, 32'h99, 1'b0, 1'b0};
    tv[7]  = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd9, 1'b0, 5'd0, 32'h0, 32'h99, 1'b0, 1'b0};
    tv[8]  = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd9, 1'b1, 5'd9, 32'h0, 32'h99, 1'b0, 1'b0};
    tv[9]  = '{1'b1, 5'd9, 32'hA5,       5'd9, 5'd9, 1'b1, 5'd9, 32'hA5, 32'hA5, 1'b0, 1'b0};
    tv[10] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd9, 1'b0, 5'd0, 32'h0, 32'hA5, 1'b0, 1'b1};
    tv[11] = '{1'b1, 5'd5, 32'h55,       5'd5, 5'd6, 1'b1, 5'd6, 32'h55, 32'h0, 1'b0, 1'b0};
    tv[12] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd6, 1'b0, 5'd0, 32'h55, 32'h0, 1'b0, 1'b1};
    tv[13] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd5, 1'b0, 5'd0, 32'h0, 32'h55, 1'b0, 1'b0};

    idle(); ra1 = 5'd5; ra2 = 5'd9;
    clr64 = 0; we64 = 0; wa64 = '0; wd64 = '0; iss64 = 0; ia64 = '0; ra1_64 = '0; ra2_64 = '0;

    repeat (3) tick();
    #4;
    chk("rst_busy", busy, 1);
    chk("rst_rd1", rd1, 0);
    chk("rst_pend", {rd1_pend, rd2_pend}, 0);
    tick();
    rst = 0;

    wait_ready(0, n, errs);
    chk("reset_busy_len", n, 32);
    chk("reset_blank", errs, 0);
    for (int a = 0; a < DEPTH; a++) begin
      ra1 = AW'(a); ra2 = AW'(DEPTH - 1 - a);
      #4;
      chk($sformatf("zero_rd1[%0d]", a), rd1, 0);
      chk($sformatf("zero_rd2[%0d]", DEPTH - 1 - a), rd2, 0);
      tick();
    end

    for (int i = 0; i < 14; i++) begin
      we = tv[i].we; wa = tv[i].wa; wd = tv[i].wd; ra1 = tv[i].ra1; ra2 = tv[i].ra2;
      iss_en = tv[i].iss; iss_addr = tv[i].ia;
      #4;
      chk($sformatf("v%0d_rd1", i), rd1, tv[i].e1);
      chk($sformatf("v%0d_rd2", i), rd2, tv[i].e2);
      chk($sformatf("v%0d_p1", i), rd1_pend, tv[i].ep1);
      chk($sformatf("v%0d_p2", i), rd2_pend, tv[i].ep2);
      tick();
    end

    // clr with a write and an issue in the same cycle; both must be dropped.
    idle(); clr = 1; we = 1; wa = 5'd5; wd = 32'h77; iss_en = 1; iss_addr = 5'd7;
    ra1 = 5'd5; ra2 = 5'd6;
    tick();
    idle();
    wait_ready(1'b0, n, errs);
    chk("clr_busy_len", n, 32);
    chk("clr_blank", errs, 0);
    ra1 = 5'd5; ra2 = 5'd6;
    #4;
    chk("clr_r5", rd1, 0);
    chk("clr_pend6", rd2_pend, 0);
    tick();
    ra2 = 5'd7;
    #4;
    chk("clr_pend7", rd2_pend, 0);
    tick();

    for (int c = 0; c < 1500; c++) begin
      we = 1'($urandom); wa = AW'($urandom_range(0, 7)); wd = $urandom;
      ra1 = AW'($urandom_range(0, 7)); ra2 = AW'($urandom_range(0, 7));
      iss_en = ($urandom_range(0, 2) == 0); iss_addr = AW'($urandom_range(0, 7));
      clr = ($urandom_range(0, 199) == 0);
      #4;
      chk("rnd_busy", busy, (m_cnt > 0));
      chk("rnd_rd1", rd1, m_rd(ra1));
      chk("rnd_rd2", rd2, m_rd(ra2));
      chk("rnd_p1", rd1_pend, m_pd(ra1));
      chk("rnd_p2", rd2_pend, m_pd(ra2));
      tick();
    end
    idle();

    rst64 = 0;
    wait_ready(1'b1, n, errs);
    chk("w64_busy_len", n, 8);
    chk("w64_blank", errs, 0);
    we64 = 1; wa64 = 3'd7; wd64 = 64'hFFFF_FFFF_0000_0001; ra1_64 = 3'd1; ra2_64 = 3'd7;
    #4;
    chk("w64_bypass", rd2_64, 64'hFFFF_FFFF_0000_0001);
    tick();
    we64 = 0; ra1_64 = 3'd7; ra2_64 = 3'd7;
    #4;
    chk("w64_rd1", rd1_64, 64'hFFFF_FFFF_0000_0001);
    chk("w64_rd2", rd2_64, 64'hFFFF_FFFF_0000_0001);
    tick();

    rst64 = 1;
    tick();
    rst64 = 0;
    repeat (4) tick();
    rst64 = 1;
    #1;
    chk("w64_rst_busy", busy64, 1);
    chk("w64_rst_rd", rd1_64, 0);
    @(posedge clk); #1;
    rst64 = 0;
    wait_ready(1'b1, n, errs);
    chk("w64_restart_len", n, 8);
    ra1_64 = 3'd7;
    #4;
    chk("w64_cleared7", rd1_64, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
